icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: INDEX_W, 8, log2 of line count; 256 direct-mapped lines, one 32-bit instruction per line.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rdy  input  1  global enable; low = freeze all state and hold all outputs.
REQ-005 clr  input  1  discard pending fetch (branch redirect); cache contents kept.
REQ-006 if_req  input  1  fetch request from IFetch, sampled only in IDLE.
REQ-007 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 if_valid  output  1  one-cycle pulse: if_ins holds the requested instruction.
REQ-009 if_ins  output  32  instruction returned to IFetch.
REQ-010 mc_req  output  1  line-fill request to memory controller; held high until mc_done.
REQ-011 mc_addr  output  32  fill address, word aligned ({tag, index, 2'b00}); stable while mc_req high.
REQ-012 mc_done  input  1  fill complete; mc_ins valid same cycle.
REQ-013 mc_ins  input  32  filled instruction word.

Function
REQ-014 Address split: index = if_addr[INDEX_W+1:2], tag = if_addr[31:INDEX_W+2].
REQ-015 Storage per line: valid bit, tag, 32-bit data.
REQ-016 FSM states: IDLE, MISS.
REQ-017 IDLE, if_req=1, clr=0, hit (valid and tag match): at next edge if_valid<=1, if_ins<=line data; stay IDLE; latency 1 cycle.
REQ-018 IDLE, if_req=1, clr=0, miss: latch address; go MISS; mc_req=1 and mc_addr valid from the next cycle.
REQ-019 MISS: mc_req stays high, mc_addr constant, until the edge at which mc_done=1.
REQ-020 MISS, edge with mc_done=1: write line (valid=1, tag, mc_ins); mc_req<=0; if_valid<=1, if_ins<=mc_ins unless the fetch was cancelled; go IDLE.
REQ-021 if_valid is a single-cycle pulse; it is 0 in every other cycle.
REQ-022 if_req in MISS is ignored; IFetch reissues after if_valid.
REQ-023 clr=1 in IDLE: the request in that cycle is dropped; no if_valid.
REQ-024 clr=1 in MISS: set cancel flag; the fill runs to completion (memory controller transfer is not abortable) and the line is written; if_valid is suppressed; cancel flag cleared on return to IDLE.
REQ-025 clr and mc_done in the same MISS cycle: line written, if_valid suppressed.
REQ-026 A hit-return and a new request never overlap: the cycle after if_valid, the FSM is IDLE and accepts if_req.
REQ-027 rdy=0: no state, storage, or output register changes; mc_req and mc_addr hold value; mc_done ignored in that cycle.
REQ-028 No write path from the data side; the cache is read-only (instruction memory assumed unmodified at run time).

Reset
REQ-029 rst=1 at posedge: FSM<=IDLE, all valid bits<=0, cancel flag<=0, if_valid<=0, if_ins<=0, mc_req<=0, mc_addr<=0.
REQ-030 rst takes priority over rdy and clr; a reset mid-MISS abandons the fill with no line written.
REQ-031 Tag and data arrays need no reset.

Verification
REQ-032 Cold miss: after reset, if_req, if_addr=0x00001004; mc_done with mc_ins=0x00500093 after 4 cycles -> mc_addr=0x00001004 throughout, one if_valid pulse with if_ins=0x00500093 the cycle after mc_done.
REQ-033 Hit: reissue 0x00001004 -> if_valid 1 cycle later, if_ins=0x00500093, mc_req stays 0.
REQ-034 Conflict: fetch 0x00001404 (same index, different tag) -> miss, fill replaces line; then refetch 0x00001004 -> miss again.
REQ-035 Cancel: miss on 0x00002000, clr pulse 1 cycle later, fill 0xDEADBEEF -> no if_valid; a later fetch of 0x00002000 hits and returns 0xDEADBEEF.
REQ-036 Stall: rdy=0 for 3 cycles during MISS with mc_done asserted in one of them -> outputs frozen, done ignored; fill completes on the next mc_done with rdy=1.
REQ-037 Reset mid-MISS: rst during a fill of 0x00003000 -> mc_req=0 next cycle; a later fetch of 0x00003000 misses.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the fetch unit / memory model.
interface icache_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_ins;

    modport slave (
        input  if_req, if_addr, mc_done, mc_ins,
        output if_valid, if_ins, mc_req, mc_addr
    );

    modport master (
        output if_req, if_addr, mc_done, mc_ins,
        input  if_valid, if_ins, mc_req, mc_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Misses are filled from the memory controller; a branch redirect cancels the pending return.
module icache #(
    parameter int unsigned INDEX_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic clr,
    icache_if.slave bus
);
    localparam int unsigned Lines = 1 << INDEX_W;
    localparam int unsigned TagW  = 30 - INDEX_W;

    typedef enum logic {StIdle, StMiss} state_e;

    state_e        state_q, state_d;
    logic          cancel_q, cancel_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_ins_q, if_ins_d;
    logic          mc_req_q, mc_req_d;
    logic [29:0]   addr_q, addr_d;
    logic          fill_we;

    logic [Lines-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TagW-1:0]    req_tag, fill_tag;
    logic               hit;
    logic               unused_addr_bits;

    assign req_idx  = bus.if_addr[INDEX_W+1:2];
    assign req_tag  = bus.if_addr[31:INDEX_W+2];
    assign fill_idx = addr_q[INDEX_W-1:0];
    assign fill_tag = addr_q[29:INDEX_W];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // Byte offset within the word is irrelevant to an instruction fetch.
    assign unused_addr_bits = ^bus.if_addr[1:0];

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        if_valid_d = 1'b0;
        if_ins_d   = if_ins_q;
        mc_req_d   = mc_req_q;
        addr_d     = addr_q;
        fill_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.if_req && !clr) begin
                    if (hit) begin
                        if_valid_d = 1'b1;
                        if_ins_d   = data_q[req_idx];
                    end else begin
                        addr_d   = bus.if_addr[31:2];
                        mc_req_d = 1'b1;
                        state_d  = StMiss;
                    end
                end
            end
            StMiss: begin
                if (clr) begin
                    cancel_d = 1'b1;
                end
                if (bus.mc_done) begin
                    fill_we  = 1'b1;
                    mc_req_d = 1'b0;
                    cancel_d = 1'b0;
                    state_d  = StIdle;
                    // A redirect in the completing cycle also suppresses the return.
                    if (!cancel_q && !clr) begin
                        if_valid_d = 1'b1;
                        if_ins_d   = bus.mc_ins;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cancel_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_ins_q   <= '0;
            mc_req_q   <= 1'b0;
            addr_q     <= '0;
            valid_q    <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cancel_q   <= cancel_d;
            if_valid_q <= if_valid_d;
            if_ins_q   <= if_ins_d;
            mc_req_q   <= mc_req_d;
            addr_q     <= addr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.mc_ins;
        end
    end

    assign bus.if_valid = if_valid_q;
    assign bus.if_ins   = if_ins_q;
    assign bus.mc_req   = mc_req_q;
    assign bus.mc_addr  = {addr_q, 2'b00};
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hit, conflict, cancel, stall and reset-during-fill.
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic clr = 1'b0;
    int   passed = 0;
    int   total  = 0;

    icache_if bus ();

    icache #(.INDEX_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        bus.if_req  = 1'b0;
    endtask

    task automatic fill(input logic [31:0] data);
        bus.mc_done = 1'b1;
        bus.mc_ins  = data;
        tick();
        bus.mc_done = 1'b0;
    endtask

    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.mc_done = 1'b0;
        bus.mc_ins  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_ins", bus.if_ins, 32'd0);
        check("rst_mc_req", {31'd0, bus.mc_req}, 32'd0);
        check("rst_mc_addr", bus.mc_addr, 32'd0);

        // Cold miss with fill 4 cycles after the request is seen.
        req(32'h0000_1004);
        check("cold_mc_req", {31'd0, bus.mc_req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("cold_mc_addr", bus.mc_addr, 32'h0000_1004);
            check("cold_no_valid", {31'd0, bus.if_valid}, 32'd0);
            tick();
        end
        check("cold_mc_req_held", {31'd0, bus.mc_req}, 32'd1);
        fill(32'h0050_0093);
        check("cold_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("cold_if_ins", bus.if_ins, 32'h0050_0093);
        check("cold_mc_req_drop", {31'd0, bus.mc_req}, 32'd0);
        tick();
        check("cold_pulse_end", {31'd0, bus.if_valid}, 32'd0);

        // Hit, then a back-to-back second hit the cycle after if_valid.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1004;
        tick();
        check("hit_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("hit_if_ins", bus.if_ins, 32'h0050_0093);
        check("hit_mc_req", {31'd0, bus.mc_req}, 32'd0);
        tick();
        bus.if_req = 1'b0;
        check("hit2_if_valid", {31'd0, bus.if_valid}, 32'd1);
        tick();
        check("hit_pulse_end", {31'd0, bus.if_valid}, 32'd0);

        // clr in IDLE drops even a hitting request.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_1004;
        clr         = 1'b1;
        tick();
        bus.if_req = 1'b0;
        clr        = 1'b0;
        check("clr_idle_valid", {31'd0, bus.if_valid}, 32'd0);
        check("clr_idle_mc_req", {31'd0, bus.mc_req}, 32'd0);

        // Conflict: same index, different tag evicts the line.
        req(32'h0000_1404);
        check("conf_mc_req", {31'd0, bus.mc_req}, 32'd1);
        check("conf_mc_addr", bus.mc_addr, 32'h0000_1404);
        fill(32'h1111_2222);
        check("conf_if_ins", bus.if_ins, 32'h1111_2222);
        tick();
        req(32'h0000_1004);
        check("conf_refetch_miss", {31'd0, bus.mc_req}, 32'd1);
        check("conf_refetch_addr", bus.mc_addr, 32'h0000_1004);
        fill(32'h0050_0093);
        check("conf_refill_ins", bus.if_ins, 32'h0050_0093);
        tick();

        // Cancel during MISS: fill completes, return suppressed, line kept.
        req(32'h0000_2000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        fill(32'hDEAD_BEEF);
        check("cancel_no_valid", {31'd0, bus.if_valid}, 32'd0);
        check("cancel_mc_req", {31'd0, bus.mc_req}, 32'd0);
        req(32'h0000_2000);
        check("cancel_hit_valid", {31'd0, bus.if_valid}, 32'd1);
        check("cancel_hit_ins", bus.if_ins, 32'hDEAD_BEEF);
        check("cancel_hit_mc_req", {31'd0, bus.mc_req}, 32'd0);
        tick();

        // clr coinciding with mc_done.
        req(32'h0000_4008);
        clr = 1'b1;
        fill(32'hCAFE_0001);
        clr = 1'b0;
        check("clrdone_no_valid", {31'd0, bus.if_valid}, 32'd0);
        check("clrdone_mc_req", {31'd0, bus.mc_req}, 32'd0);
        req(32'h0000_4008);
        check("clrdone_hit_ins", bus.if_ins, 32'hCAFE_0001);
        check("clrdone_hit_valid", {31'd0, bus.if_valid}, 32'd1);
        tick();

        // Stall: rdy low for 3 cycles, mc_done in the middle one is ignored.
        req(32'h0000_5010);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mc_done = (i == 1);
            bus.mc_ins  = 32'h0BAD_0BAD;
            tick();
            check("stall_mc_req", {31'd0, bus.mc_req}, 32'd1);
            check("stall_mc_addr", bus.mc_addr, 32'h0000_5010);
            check("stall_no_valid", {31'd0, bus.if_valid}, 32'd0);
        end
        bus.mc_done = 1'b0;
        rdy         = 1'b1;
        tick();
        check("stall_still_miss", {31'd0, bus.mc_req}, 32'd1);
        fill(32'h1234_5678);
        check("stall_if_valid", {31'd0, bus.if_valid}, 32'd1);
        check("stall_if_ins", bus.if_ins, 32'h1234_5678);
        tick();

        // Reset mid-MISS abandons the fill.
        req(32'h0000_3000);
        check("rstmiss_mc_req", {31'd0, bus.mc_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmiss_mc_req_drop", {31'd0, bus.mc_req}, 32'd0);
        check("rstmiss_mc_addr", bus.mc_addr, 32'd0);
        req(32'h0000_3000);
        check("rstmiss_refetch_miss", {31'd0, bus.mc_req}, 32'd1);
        check("rstmiss_refetch_valid", {31'd0, bus.if_valid}, 32'd0);
        fill(32'h0000_3333);
        check("rstmiss_fill_ins", bus.if_ins, 32'h0000_3333);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
